// File: rtl/gfau_seq.sv
// Program sequencer for an external arithmetic unit: it fetches instructions from a 16-entry
// program memory, issues each one to the unit, and writes the result back into an 8-entry RF.
module gfau_seq #(
    parameter int SIZE    = 33,
    parameter int TIMEOUT = 1023
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            reg_wr_en,
    input  logic [2:0]      reg_wr_addr,
    input  logic [SIZE-1:0] reg_wr_data,
    input  logic [2:0]      reg_rd_addr,
    output logic [SIZE-1:0] reg_rd_data,
    input  logic            prog_wr_en,
    input  logic [3:0]      prog_wr_addr,
    input  logic [10:0]     prog_wr_data,
    input  logic [3:0]      prog_last,
    input  logic            start,
    output logic            busy,
    output logic            done,
    output logic            error,
    output logic [SIZE-1:0] gfau_in_0,
    output logic [SIZE-1:0] gfau_in_1,
    output logic [1:0]      gfau_op,
    output logic            gfau_start,
    input  logic [SIZE-1:0] gfau_result,
    input  logic            gfau_done
);

    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_ISSUE = 3'd2,
        S_WAIT  = 3'd3,
        S_WRITE = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       pc_q, pc_d;
    logic [3:0]       last_q, last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic [10:0]      instr_q, instr_d;
    logic [10:0]      fetch_instr;
    logic [SIZE-1:0]  res_q, res_d;
    logic [SIZE-1:0]  in0_q, in0_d;
    logic [SIZE-1:0]  in1_q, in1_d;
    logic [1:0]       op_q, op_d;

    logic [SIZE-1:0]  rf_q [8];
    logic [10:0]      imem_q [16];

    logic             rf_we;
    logic [2:0]       rf_waddr;
    logic [SIZE-1:0]  rf_wdata;
    logic             imem_we;

    assign fetch_instr = imem_q[pc_q];

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        last_d   = last_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        instr_d  = instr_q;
        res_d    = res_q;
        in0_d    = in0_q;
        in1_d    = in1_q;
        op_d     = op_q;
        rf_we    = 1'b0;
        rf_waddr = reg_wr_addr;
        rf_wdata = reg_wr_data;
        imem_we  = 1'b0;

        case (state_q)
            S_IDLE: begin
                // Host writes land on the same edge that accepts start, so FETCH sees them.
                rf_we   = reg_wr_en;
                imem_we = prog_wr_en;
                if (start) begin
                    last_d  = prog_last;
                    pc_d    = 4'd0;
                    err_d   = 1'b0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                instr_d = fetch_instr;
                in0_d   = rf_q[fetch_instr[5:3]];
                in1_d   = rf_q[fetch_instr[2:0]];
                op_d    = fetch_instr[10:9];
                state_d = S_ISSUE;
            end
            S_ISSUE: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (gfau_done) begin
                    res_d   = gfau_result;
                    state_d = S_WRITE;
                end else if (cnt_q == CNT_LAST) begin
                    // This is the TIMEOUT-th cycle without a result: abandon the program.
                    cnt_d   = cnt_q + CNT_W'(1);
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            S_WRITE: begin
                rf_we    = 1'b1;
                rf_waddr = instr_q[8:6];
                rf_wdata = res_q;
                if (pc_q == last_q) begin
                    state_d = S_DONE;
                end else begin
                    pc_d    = pc_q + 4'd1;
                    state_d = S_FETCH;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            last_q  <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            in0_q   <= '0;
            in1_q   <= '0;
            op_q    <= '0;
            for (int i = 0; i < 8; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            in0_q   <= in0_d;
            in1_q   <= in1_d;
            op_q    <= op_d;
            if (rf_we) begin
                rf_q[rf_waddr] <= rf_wdata;
            end
        end
    end

    // The instruction and result holding registers need no reset: both are always
    // loaded before they are used.
    always_ff @(posedge i_clk) begin
        instr_q <= instr_d;
        res_q   <= res_d;
    end

    // Program memory deliberately survives reset so a program can be rerun after an abort.
    always_ff @(posedge i_clk) begin
        if (imem_we) begin
            imem_q[prog_wr_addr] <= prog_wr_data;
        end
    end

    assign reg_rd_data = rf_q[reg_rd_addr];
    assign busy        = (state_q == S_FETCH) || (state_q == S_ISSUE) ||
                         (state_q == S_WAIT)  || (state_q == S_WRITE);
    assign done        = (state_q == S_DONE);
    assign error       = err_q;
    assign gfau_start  = (state_q == S_ISSUE);
    assign gfau_in_0   = in0_q;
    assign gfau_in_1   = in1_q;
    assign gfau_op     = op_q;

endmodule

// File: tb/tb_gfau_seq.sv
// Bench for gfau_seq: a GF(23) arithmetic unit with 3 busy cycles drives the result port;
// a program-level model of the register file predicts every result.
module tb_gfau_seq;

    localparam int SIZE = 33;

    logic            clk;
    logic            i_rst;
    logic            reg_wr_en;
    logic [2:0]      reg_wr_addr;
    logic [SIZE-1:0] reg_wr_data;
    logic [2:0]      reg_rd_addr;
    logic [SIZE-1:0] reg_rd_data;
    logic            prog_wr_en;
    logic [3:0]      prog_wr_addr;
    logic [10:0]     prog_wr_data;
    logic [3:0]      prog_last;
    logic            start;
    logic            busy;
    logic            done;
    logic            error;
    logic [SIZE-1:0] gfau_in_0;
    logic [SIZE-1:0] gfau_in_1;
    logic [1:0]      gfau_op;
    logic            gfau_start;
    logic [SIZE-1:0] gfau_result;
    logic            gfau_done;

    gfau_seq #(.SIZE(SIZE), .TIMEOUT(1023)) dut (
        .i_clk(clk), .i_rst(i_rst),
        .reg_wr_en(reg_wr_en), .reg_wr_addr(reg_wr_addr), .reg_wr_data(reg_wr_data),
        .reg_rd_addr(reg_rd_addr), .reg_rd_data(reg_rd_data),
        .prog_wr_en(prog_wr_en), .prog_wr_addr(prog_wr_addr), .prog_wr_data(prog_wr_data),
        .prog_last(prog_last), .start(start), .busy(busy), .done(done), .error(error),
        .gfau_in_0(gfau_in_0), .gfau_in_1(gfau_in_1), .gfau_op(gfau_op),
        .gfau_start(gfau_start), .gfau_result(gfau_result), .gfau_done(gfau_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Arithmetic unit environment state
    int              au_cnt = 0;
    logic            au_en = 1'b1;
    logic            au_done = 1'b0;
    logic            stray = 1'b0;
    logic [SIZE-1:0] au_res = '0;
    logic [SIZE-1:0] au_in0 = '0;
    logic [SIZE-1:0] au_in1 = '0;
    logic [1:0]      au_op = '0;
    int              n_starts = 0;
    int              n_done = 0;

    // Reference state: what the RF and program memory should hold
    logic [SIZE-1:0] m_rf [8];
    logic [10:0]     m_imem [16];

    typedef struct {
        logic [1:0]      op;
        logic [2:0]      dst;
        logic [2:0]      sa;
        logic [2:0]      sb;
        logic [SIZE-1:0] va;
        logic [SIZE-1:0] vb;
        logic [SIZE-1:0] exp;
    } vec_t;

    typedef struct {
        int   lat;
        logic seen;
        logic err1;
        logic err_done;
        logic busy_done;
        logic done_next;
    } run_t;

    function automatic logic [SIZE-1:0] gf(input logic [1:0] op, input logic [SIZE-1:0] a,
                                           input logic [SIZE-1:0] b);
        longint x, y, r;
        x = longint'(a) % 23;
        y = longint'(b) % 23;
        r = 0;
        case (op)
            2'd0: r = (x + y) % 23;
            2'd1: r = (x - y + 23) % 23;
            2'd2: r = (x * y) % 23;
            default: begin
                for (int k = 1; k < 23; k++) begin
                    if ((y * k) % 23 == 1) r = (x * k) % 23;
                end
            end
        endcase
        return SIZE'(r);
    endfunction

    always @(negedge clk) begin
        au_done = 1'b0;
        if (au_cnt > 0) begin
            au_cnt = au_cnt - 1;
            if (au_cnt == 0 && au_en) au_done = 1'b1;
        end
        if (gfau_start === 1'b1) begin
            au_cnt   = 4;
            au_in0   = gfau_in_0;
            au_in1   = gfau_in_1;
            au_op    = gfau_op;
            au_res   = gf(gfau_op, gfau_in_0, gfau_in_1);
            n_starts = n_starts + 1;
        end
        if (done === 1'b1) n_done = n_done + 1;
    end

    assign gfau_result = au_res;
    assign gfau_done   = au_done | stray;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk = n_chk + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic wr_reg(input logic [2:0] a, input logic [SIZE-1:0] d);
        @(negedge clk);
        reg_wr_en = 1'b1; reg_wr_addr = a; reg_wr_data = d;
        @(negedge clk);
        reg_wr_en = 1'b0;
        m_rf[a] = d;
    endtask

    task automatic wr_prog(input logic [3:0] a, input logic [10:0] d);
        @(negedge clk);
        prog_wr_en = 1'b1; prog_wr_addr = a; prog_wr_data = d;
        @(negedge clk);
        prog_wr_en = 1'b0;
        m_imem[a] = d;
    endtask

    task automatic chk_rf(input string nm, input logic [2:0] a, input logic [SIZE-1:0] e);
        @(negedge clk);
        reg_rd_addr = a;
        #1;
        chk(nm, 64'(reg_rd_data), 64'(e));
    endtask

    task automatic model_run(input int last);
        logic [10:0] ins;
        for (int p = 0; p <= last; p++) begin
            ins = m_imem[p];
            m_rf[ins[8:6]] = gf(ins[10:9], m_rf[ins[5:3]], m_rf[ins[2:0]]);
        end
    endtask

    task automatic run(input logic [3:0] last, output run_t r);
        @(negedge clk);
        n_starts  = 0;
        n_done    = 0;
        prog_last = last;
        start     = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        r.lat  = 1;
        r.err1 = error;
        while (done !== 1'b1 && r.lat < 3000) begin
            @(negedge clk);
            r.lat = r.lat + 1;
        end
        r.seen      = (done === 1'b1);
        r.err_done  = error;
        r.busy_done = busy;
        @(negedge clk);
        #1;
        r.done_next = done;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, summary not reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[9];
        run_t r;
        int   len;
        int   wt;

        tbl[0] = '{2'd0, 3'd3, 3'd1, 3'd2, 33'd5,  33'd20, 33'd2};
        tbl[1] = '{2'd1, 3'd4, 3'd1, 3'd2, 33'd5,  33'd20, 33'd8};
        tbl[2] = '{2'd2, 3'd3, 3'd1, 3'd2, 33'd5,  33'd20, 33'd8};
        tbl[3] = '{2'd3, 3'd5, 3'd1, 3'd2, 33'd20, 33'd5,  33'd4};
        tbl[4] = '{2'd3, 3'd6, 3'd2, 3'd7, 33'd1,  33'd2,  33'd12};
        tbl[5] = '{2'd0, 3'd0, 3'd6, 3'd7, 33'd22, 33'd22, 33'd21};
        tbl[6] = '{2'd2, 3'd7, 3'd5, 3'd0, 33'd22, 33'd22, 33'd1};
        tbl[7] = '{2'd1, 3'd2, 3'd3, 3'd4, 33'd0,  33'd1,  33'd22};
        tbl[8] = '{2'd0, 3'd1, 3'd1, 3'd1, 33'd7,  33'd7,  33'd14};

        for (int i = 0; i < 8; i++) m_rf[i] = '0;
        for (int i = 0; i < 16; i++) m_imem[i] = '0;
        i_rst = 1'b0; start = 1'b0; prog_last = '0;
        reg_wr_en = 1'b0; reg_wr_addr = '0; reg_wr_data = '0; reg_rd_addr = '0;
        prog_wr_en = 1'b0; prog_wr_addr = '0; prog_wr_data = '0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_error", 64'(error), 64'd0);
        chk("rst_gfau_start", 64'(gfau_start), 64'd0);
        chk("rst_in0", 64'(gfau_in_0), 64'd0);
        chk("rst_in1", 64'(gfau_in_1), 64'd0);
        chk("rst_op", 64'(gfau_op), 64'd0);
        i_rst = 1'b1;
        for (int i = 0; i < 8; i++) chk_rf("rst_rf", 3'(i), '0);

        // Single-instruction vectors, including aliasing and division
        foreach (tbl[i]) begin
            wr_reg(tbl[i].sa, tbl[i].va);
            wr_reg(tbl[i].sb, tbl[i].vb);
            wr_prog(4'd0, {tbl[i].op, tbl[i].dst, tbl[i].sa, tbl[i].sb});
            model_run(0);
            run(4'd0, r);
            chk("tbl_done_seen", 64'(r.seen), 64'd1);
            chk("tbl_latency", 64'(r.lat), 64'd8);
            chk("tbl_busy_at_done", 64'(r.busy_done), 64'd0);
            chk("tbl_done_pulse", 64'(r.done_next), 64'd0);
            chk("tbl_starts", 64'(n_starts), 64'd1);
            chk("tbl_error", 64'(r.err_done), 64'd0);
            chk_rf("tbl_result", tbl[i].dst, tbl[i].exp);
        end

        // Two-instruction chain: second reads the first one's write
        wr_reg(3'd1, 33'd5);
        wr_reg(3'd2, 33'd20);
        wr_prog(4'd0, {2'd2, 3'd3, 3'd1, 3'd2});
        wr_prog(4'd1, {2'd1, 3'd4, 3'd3, 3'd1});
        model_run(1);
        run(4'd1, r);
        chk("chain_latency", 64'(r.lat), 64'd15);
        chk("chain_starts", 64'(n_starts), 64'd2);
        chk("chain_dones", 64'(n_done), 64'd1);
        chk_rf("chain_r3", 3'd3, 33'd8);
        chk_rf("chain_r4", 3'd4, 33'd3);

        // Full-width operands reach the unit unmodified
        wr_reg(3'd5, 33'h1_ABCD_EF01);
        wr_reg(3'd6, 33'h1_0000_0003);
        chk_rf("wide_readback", 3'd5, 33'h1_ABCD_EF01);
        wr_prog(4'd0, {2'd1, 3'd7, 3'd5, 3'd6});
        model_run(0);
        run(4'd0, r);
        chk("wide_in0", 64'(au_in0), 64'h1_ABCD_EF01);
        chk("wide_in1", 64'(au_in1), 64'h1_0000_0003);
        chk("wide_op", 64'(au_op), 64'd1);
        chk_rf("wide_result", 3'd7, m_rf[7]);

        // Timeout: the unit never answers
        wr_reg(3'd1, 33'd5);
        wr_reg(3'd2, 33'd20);
        wr_reg(3'd3, 33'd9);
        wr_prog(4'd0, {2'd0, 3'd3, 3'd1, 3'd2});
        au_en = 1'b0;
        run(4'd0, r);
        au_en = 1'b1;
        chk("to_done_seen", 64'(r.seen), 64'd1);
        chk("to_latency", 64'(r.lat), 64'd1026);
        chk("to_error", 64'(r.err_done), 64'd1);
        chk("to_busy_at_done", 64'(r.busy_done), 64'd0);
        chk("to_error_sticky", 64'(error), 64'd1);
        chk_rf("to_rf_unchanged", 3'd3, 33'd9);
        model_run(0);
        run(4'd0, r);
        chk("to_error_cleared", 64'(r.err1), 64'd0);
        chk("to_rerun_error", 64'(r.err_done), 64'd0);
        chk_rf("to_rerun_result", 3'd3, 33'd2);

        // Host traffic, a second start and a stray done while busy are all ignored
        wr_reg(3'd3, 33'd0);
        wr_reg(3'd5, 33'd17);
        @(negedge clk);
        n_starts = 0; n_done = 0;
        prog_last = 4'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b1; prog_last = 4'd5; stray = 1'b1;
        reg_wr_en = 1'b1; reg_wr_addr = 3'd1; reg_wr_data = 33'd11;
        prog_wr_en = 1'b1; prog_wr_addr = 4'd0; prog_wr_data = {2'd2, 3'd5, 3'd1, 3'd2};
        @(negedge clk);
        start = 1'b0; stray = 1'b0; reg_wr_en = 1'b0; prog_wr_en = 1'b0;
        wt = 2;
        while (done !== 1'b1 && wt < 100) begin
            @(negedge clk);
            wt = wt + 1;
        end
        chk("ign_latency", 64'(wt), 64'd8);
        @(negedge clk);
        #1;
        chk("ign_starts", 64'(n_starts), 64'd1);
        chk("ign_dones", 64'(n_done), 64'd1);
        chk_rf("ign_rf1", 3'd1, 33'd5);
        chk_rf("ign_r3", 3'd3, 33'd2);
        chk_rf("ign_r5", 3'd5, 33'd17);
        wr_reg(3'd3, 33'd0);
        model_run(0);
        run(4'd0, r);
        chk_rf("ign_imem_r3", 3'd3, 33'd2);
        chk_rf("ign_imem_r5", 3'd5, 33'd17);

        // Stray done in IDLE
        @(negedge clk);
        n_done = 0;
        stray = 1'b1;
        @(negedge clk);
        stray = 1'b0;
        chk("idle_stray_busy", 64'(busy), 64'd0);
        @(negedge clk);
        chk("idle_stray_busy2", 64'(busy), 64'd0);
        chk("idle_stray_done", 64'(done), 64'd0);
        chk_rf("idle_stray_rf", 3'd3, 33'd2);

        // Reset while waiting on the unit
        wr_reg(3'd3, 33'd0);
        @(negedge clk);
        n_done = 0;
        prog_last = 4'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        chk("rw_busy_before", 64'(busy), 64'd1);
        i_rst = 1'b0;
        @(negedge clk);
        i_rst = 1'b1;
        chk("rw_busy", 64'(busy), 64'd0);
        chk("rw_done", 64'(done), 64'd0);
        chk("rw_gfau_start", 64'(gfau_start), 64'd0);
        for (int i = 0; i < 8; i++) m_rf[i] = '0;
        for (int i = 0; i < 8; i++) chk_rf("rw_rf_clear", 3'(i), '0);
        repeat (4) @(negedge clk);
        #1;
        chk("rw_no_done", 64'(n_done), 64'd0);
        wr_reg(3'd1, 33'd5);
        wr_reg(3'd2, 33'd20);
        model_run(0);
        run(4'd0, r);
        chk("rw_rerun_seen", 64'(r.seen), 64'd1);
        chk_rf("rw_rerun_r3", 3'd3, 33'd2);

        // Random programs against the program-level model
        for (int it = 0; it < 20; it++) begin
            len = int'($urandom_range(1, 16));
            for (int k = 0; k < 8; k++) wr_reg(3'(k), SIZE'($urandom_range(0, 22)));
            for (int p = 0; p < len; p++) wr_prog(4'(p), 11'($urandom_range(0, 2047)));
            model_run(len - 1);
            run(4'(len - 1), r);
            chk("rnd_latency", 64'(r.lat), 64'(1 + 7 * len));
            chk("rnd_starts", 64'(n_starts), 64'(len));
            chk("rnd_error", 64'(r.err_done), 64'd0);
            for (int k = 0; k < 8; k++) chk_rf("rnd_rf", 3'(k), m_rf[k]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/gfau_seq.md
GFAU_SEQ -- requirements
Module: gfau_seq

Interface
REQ-001 SHALL have parameter SIZE, default 33, giving the operand and result width.
REQ-002 SHALL have parameter TIMEOUT, default 1023, giving the maximum WAIT cycles per operation (10-bit counter).
REQ-003 i_clk  in  1  single clock; all state changes on its rising edge.
REQ-004 i_rst  in  1  synchronous, active-low reset.
REQ-005 reg_wr_en / reg_wr_addr / reg_wr_data  in  1/3/SIZE  host write to the 8-entry operand register file (RF).
REQ-006 reg_rd_addr  in  3  host read address; reg_rd_data  out  SIZE  combinational RF[reg_rd_addr].
REQ-007 prog_wr_en / prog_wr_addr / prog_wr_data  in  1/4/11  host write to the 16-entry instruction memory; instruction fields [10:9]=op, [8:6]=dst, [5:3]=srcA, [2:0]=srcB.
REQ-008 prog_last  in  4  index of the last instruction to execute; it is sampled at start.
REQ-009 start  in  1  one-cycle run request.
REQ-010 busy  out  1  high from the cycle after an accepted start until DONE.
REQ-011 done  out  1  one-cycle completion pulse.
REQ-012 error  out  1  sticky timeout flag.
REQ-013 gfau_in_0 / gfau_in_1  out  SIZE  operands to the arithmetic unit; gfau_op  out  2  operation code (0 add, 1 sub, 2 mult, 3 div).
REQ-014 gfau_start  out  1  one-cycle operation request; gfau_result  in  SIZE; gfau_done  in  1  result-valid pulse.

Function
REQ-015 States SHALL be IDLE, FETCH, ISSUE, WAIT, WRITE and DONE, with a 4-bit pc.
REQ-016 IDLE: on start=1, the block SHALL latch prog_last, set pc=0, clear error and go to FETCH; start in any other state SHALL be ignored.
REQ-017 FETCH (1 cycle): the block SHALL register imem[pc] and drive gfau_in_0=RF[srcA], gfau_in_1=RF[srcB] and gfau_op=op, then go to ISSUE.
REQ-018 gfau_in_0, gfau_in_1 and gfau_op SHALL hold stable from FETCH through the end of WAIT.
REQ-019 ISSUE (1 cycle): gfau_start SHALL be 1, the timeout counter SHALL clear, and the state SHALL go to WAIT.
REQ-020 gfau_start SHALL be 0 in every state other than ISSUE.
REQ-021 WAIT: on gfau_done=1 the block SHALL capture gfau_result and go to WRITE.
REQ-022 WAIT: otherwise the timeout counter SHALL increment.
REQ-023 WAIT timeout: when the counter reaches TIMEOUT without gfau_done, the block SHALL set error=1, make no RF write, and go to DONE.
REQ-024 WRITE (1 cycle): the block SHALL write RF[dst] with the captured result.
REQ-025 WRITE exit: if pc==latched prog_last the state SHALL go to DONE; otherwise pc SHALL increment and the state SHALL go to FETCH.
REQ-026 DONE (1 cycle): done SHALL be 1, busy SHALL be 0 in the same cycle, and the state SHALL go to IDLE.
REQ-027 gfau_done pulses outside WAIT SHALL be ignored.
REQ-028 Per-instruction latency SHALL be 4 cycles plus the arithmetic unit's latency, measured from FETCH entry to WRITE exit.
REQ-029 Register aliasing: dst may equal srcA or srcB; operands SHALL be those read in FETCH, and a later instruction SHALL see the WRITE value.
REQ-030 Host reg_wr_en and prog_wr_en SHALL take effect only in IDLE and SHALL be ignored otherwise.
REQ-031 A host RF write in the same cycle as an accepted start SHALL complete before FETCH.
REQ-032 No arithmetic SHALL be performed on data; values pass through unmodified at full SIZE width.

Reset
REQ-033 i_rst=0 at a clock edge SHALL force IDLE and clear pc, the timeout counter, all RF entries, gfau_in_0, gfau_in_1 and gfau_op.
REQ-034 i_rst=0 at a clock edge SHALL drive busy=0, done=0, error=0 and gfau_start=0.
REQ-035 Instruction memory SHALL NOT be reset.
REQ-036 Reset asserted mid-program (any state) SHALL abort with no further RF write and no done pulse.

Verification
REQ-037 Bench arithmetic model: prime 23, 3-cycle result latency.
REQ-038 Single add: RF1=5, RF2=20, imem0={add,dst3,src1,src2}, prog_last=0, start -> gfau_start once; RF3=2; done 8 cycles after start; error=0.
REQ-039 Chain: imem0={mult,r3,r1,r2}, imem1={sub,r4,r3,r1}, prog_last=1 with RF1=5, RF2=20 -> RF3=8, RF4=3; exactly two gfau_start pulses; one done.
REQ-040 Aliasing: imem0={add,r1,r1,r1} with RF1=7, prog_last=0 -> RF1=14.
REQ-041 Timeout: model never asserts gfau_done -> after 1023 WAIT cycles error=1 and done pulses; target RF unchanged; the next start clears error.
REQ-042 Ignored inputs: start, reg_wr_en and a stray gfau_done while busy -> no effect on pc or RF; stray gfau_done in IDLE -> no state change.
REQ-043 Reset in WAIT: i_rst=0 for 1 cycle -> next cycle IDLE, busy=0, all RF=0, no done; instruction memory intact; rerun produces the correct result.
